// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte master and its half-period timer.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_t;

   localparam logic [7:0] DROP_SAT = 8'hFF;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: one-cycle tick every CLK_DIV cycles while a transfer is active.
module spi_half_tick
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic       CLK_1KHZ,
   input  logic       RESET,
   input  spi_state_t state,
   output logic       tick
);
   localparam int CNT_W = $clog2(CLK_DIV + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             en_s;
   logic             wrap_s;

   assign en_s   = (state != ST_IDLE);
   assign wrap_s = (cnt_r == CNT_W'(CLK_DIV - 1));
   assign tick   = en_s & wrap_s;

   // Divider counter, held at zero while idle so every transfer starts phase-aligned.
   always_ff @(posedge CLK_1KHZ) begin
      if (RESET) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (!en_s || wrap_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_byte_master.sv
// SPI master (CPHA=0, CPOL selectable): one DATA_W-bit transfer per accepted START rising edge,
// with MISO capture and a saturating count of START edges rejected while busy.
module spi_byte_master
   import spi_pkg::*;
#(
   parameter int   DATA_W  = 8,
   parameter int   CLK_DIV = 1,
   parameter logic CPOL    = 1'b0
) (
   input  logic              CLK_1KHZ,
   input  logic              RESET,
   input  logic              START,
   input  logic [DATA_W-1:0] DATA,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic              SS_N,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              DONE,
   output logic              BUSY,
   output logic [7:0]        DROP_CNT
);
   localparam int              HC_W       = $clog2(2*DATA_W + 1);
   localparam logic [HC_W-1:0] LAST_EDGE  = HC_W'(2*DATA_W);
   localparam logic [HC_W-1:0] LAST_TRAIL = HC_W'(2*DATA_W - 1);

   spi_state_t        state_r, state_next_s;
   logic              start_d_r;
   logic              edge_s;
   logic              tick_s;
   logic [DATA_W-1:0] tx_sr_r, tx_sr_next_s, tx_shift_s;
   logic [DATA_W-1:0] rx_sr_r, rx_sr_next_s;
   logic [HC_W-1:0]   half_cnt_r, half_cnt_next_s;
   logic              sclk_r, sclk_next_s;
   logic              mosi_r, mosi_next_s;
   logic              ss_n_r, ss_n_next_s;
   logic [DATA_W-1:0] rx_data_r, rx_data_next_s;
   logic              done_r, done_next_s;
   logic              busy_r;
   logic [7:0]        drop_cnt_r, drop_cnt_next_s;

   assign edge_s     = START & ~start_d_r;
   assign tx_shift_s = {tx_sr_r[DATA_W-2:0], 1'b0};

   assign SCLK     = sclk_r;
   assign MOSI     = mosi_r;
   assign SS_N     = ss_n_r;
   assign RX_DATA  = rx_data_r;
   assign DONE     = done_r;
   assign BUSY     = busy_r;
   assign DROP_CNT = drop_cnt_r;

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
      .CLK_1KHZ (CLK_1KHZ),
      .RESET    (RESET),
      .state    (state_r),
      .tick     (tick_s)
   );

   // FSM state register.
   always_ff @(posedge CLK_1KHZ) begin
      if (RESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and next-value logic for the serial datapath; half_cnt_r counts SCLK edges made.
   always_comb begin
      state_next_s    = state_r;
      tx_sr_next_s    = tx_sr_r;
      rx_sr_next_s    = rx_sr_r;
      half_cnt_next_s = half_cnt_r;
      sclk_next_s     = sclk_r;
      mosi_next_s     = mosi_r;
      ss_n_next_s     = ss_n_r;
      rx_data_next_s  = rx_data_r;
      done_next_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (edge_s) begin
               tx_sr_next_s    = DATA;
               rx_sr_next_s    = {DATA_W{1'b0}};
               half_cnt_next_s = {HC_W{1'b0}};
               mosi_next_s     = DATA[DATA_W-1];
               ss_n_next_s     = 1'b0;
               state_next_s    = ST_SETUP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (tick_s) begin
               sclk_next_s     = ~CPOL;
               rx_sr_next_s    = {rx_sr_r[DATA_W-2:0], MISO};
               half_cnt_next_s = HC_W'(1);
               state_next_s    = ST_SHIFT;
            end else begin
               state_next_s = ST_SETUP;
            end
         end
         ST_SHIFT: begin
            if (!tick_s) begin
               state_next_s = ST_SHIFT;
            end else if (half_cnt_r == LAST_EDGE) begin
               state_next_s = ST_HOLD;
            end else if (half_cnt_r[0]) begin
               sclk_next_s     = CPOL;
               half_cnt_next_s = half_cnt_r + HC_W'(1);
               if (half_cnt_r != LAST_TRAIL) begin
                  tx_sr_next_s = tx_shift_s;
                  mosi_next_s  = tx_shift_s[DATA_W-1];
               end else begin
                  mosi_next_s = mosi_r;
               end
            end else begin
               sclk_next_s     = ~CPOL;
               rx_sr_next_s    = {rx_sr_r[DATA_W-2:0], MISO};
               half_cnt_next_s = half_cnt_r + HC_W'(1);
            end
         end
         ST_HOLD: begin
            if (tick_s) begin
               ss_n_next_s    = 1'b1;
               rx_data_next_s = rx_sr_r;
               done_next_s    = 1'b1;
               state_next_s   = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            sclk_next_s  = CPOL;
            ss_n_next_s  = 1'b1;
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Any START edge outside IDLE is lost; the count sticks at its ceiling.
   always_comb begin
      drop_cnt_next_s = drop_cnt_r;
      if (edge_s && (state_r != ST_IDLE) && (drop_cnt_r != DROP_SAT)) begin
         drop_cnt_next_s = drop_cnt_r + 8'd1;
      end else begin
         drop_cnt_next_s = drop_cnt_r;
      end
   end

   // Datapath and output registers; start_d_r resets high so a START held through reset is not an edge.
   always_ff @(posedge CLK_1KHZ) begin
      if (RESET) begin
         start_d_r  <= 1'b1;
         tx_sr_r    <= {DATA_W{1'b0}};
         rx_sr_r    <= {DATA_W{1'b0}};
         half_cnt_r <= {HC_W{1'b0}};
         sclk_r     <= CPOL;
         mosi_r     <= 1'b0;
         ss_n_r     <= 1'b1;
         rx_data_r  <= {DATA_W{1'b0}};
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         drop_cnt_r <= 8'd0;
      end else begin
         start_d_r  <= START;
         tx_sr_r    <= tx_sr_next_s;
         rx_sr_r    <= rx_sr_next_s;
         half_cnt_r <= half_cnt_next_s;
         sclk_r     <= sclk_next_s;
         mosi_r     <= mosi_next_s;
         ss_n_r     <= ss_n_next_s;
         rx_data_r  <= rx_data_next_s;
         done_r     <= done_next_s;
         busy_r     <= (state_next_s != ST_IDLE);
         drop_cnt_r <= drop_cnt_next_s;
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: instance A (CLK_DIV=1, CPOL=0) and instance B (CLK_DIV=3, CPOL=1).
module tb_spi_byte_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, start_a, miso_a, sclk_a, mosi_a, ss_n_a, done_a, busy_a;
   logic [7:0] data_a, rx_a, drop_a;
   logic [1:0] miso_mode_a;
   logic       reset_b, start_b, miso_b, sclk_b, mosi_b, ss_n_b, done_b, busy_b;
   logic [7:0] data_b, rx_b, drop_b;
   logic [1:0] miso_mode_b;

   int checks = 0;
   int errors = 0;

   spi_byte_master #(.DATA_W(8), .CLK_DIV(1), .CPOL(1'b0)) dut_a (
      .CLK_1KHZ(clk), .RESET(reset_a), .START(start_a), .DATA(data_a), .MISO(miso_a),
      .SCLK(sclk_a), .MOSI(mosi_a), .SS_N(ss_n_a), .RX_DATA(rx_a), .DONE(done_a),
      .BUSY(busy_a), .DROP_CNT(drop_a)
   );

   spi_byte_master #(.DATA_W(8), .CLK_DIV(3), .CPOL(1'b1)) dut_b (
      .CLK_1KHZ(clk), .RESET(reset_b), .START(start_b), .DATA(data_b), .MISO(miso_b),
      .SCLK(sclk_b), .MOSI(mosi_b), .SS_N(ss_n_b), .RX_DATA(rx_b), .DONE(done_b),
      .BUSY(busy_b), .DROP_CNT(drop_b)
   );

   // MISO source: 0 = loopback from MOSI, 1 = tied high, 2 = tied low.
   always_comb begin
      miso_a = mosi_a;
      miso_b = mosi_b;
      case (miso_mode_a)
         2'd1:    miso_a = 1'b1;
         2'd2:    miso_a = 1'b0;
         default: miso_a = mosi_a;
      endcase
      case (miso_mode_b)
         2'd1:    miso_b = 1'b1;
         2'd2:    miso_b = 1'b0;
         default: miso_b = mosi_b;
      endcase
   end

   typedef struct {
      bit         inst;
      logic [7:0] data;
      logic [1:0] mode;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transfer on the chosen instance; the START edge is sampled at the first posedge (c=0).
   task automatic xfer(input bit inst, input logic [7:0] d, input logic [1:0] mode,
                       output logic [7:0] bits, output int nbits, output int ss_low,
                       output int done_c, output int done_n, output int lead1,
                       output int lead2, output logic busy_end);
      logic s, m, ss, dn, prev, cpol;
      int   div;
      cpol = inst;
      div  = inst ? 3 : 1;
      bits = 8'h00; nbits = 0; ss_low = 0; done_c = -1; done_n = 0; lead1 = -1; lead2 = -1;
      if (inst) begin
         data_b = d; miso_mode_b = mode; start_b = 1'b1;
      end else begin
         data_a = d; miso_mode_a = mode; start_a = 1'b1;
      end
      prev = inst ? sclk_b : sclk_a;
      for (int c = 0; c < 18*div + 6; c++) begin
         step();
         s  = inst ? sclk_b : sclk_a;
         m  = inst ? mosi_b : mosi_a;
         ss = inst ? ss_n_b : ss_n_a;
         dn = inst ? done_b : done_a;
         if (prev == cpol && s != cpol) begin
            if (nbits == 0) lead1 = c;
            if (nbits == 1) lead2 = c;
            if (nbits < 8) bits = {bits[6:0], m};
            nbits++;
         end
         if (!ss) ss_low++;
         if (dn) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         prev = s;
      end
      busy_end = inst ? busy_b : busy_a;
      if (inst) start_b = 1'b0;
      else      start_a = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] bits;
      int         nbits, ss_low, done_c, done_n, lead1, lead2, div, rising;
      logic       busy_end, prev, got, done_seen, busy_seen;

      vecs[0] = '{1'b0, 8'hA5, 2'd0, 8'hA5};
      vecs[1] = '{1'b0, 8'h00, 2'd1, 8'hFF};
      vecs[2] = '{1'b0, 8'h3C, 2'd0, 8'h3C};
      vecs[3] = '{1'b0, 8'hFF, 2'd2, 8'h00};
      vecs[4] = '{1'b0, 8'h81, 2'd1, 8'hFF};
      vecs[5] = '{1'b1, 8'hA5, 2'd0, 8'hA5};
      vecs[6] = '{1'b1, 8'h5A, 2'd0, 8'h5A};
      vecs[7] = '{1'b1, 8'h00, 2'd1, 8'hFF};

      reset_a = 1'b1; start_a = 1'b0; data_a = 8'h00; miso_mode_a = 2'd0;
      reset_b = 1'b1; start_b = 1'b0; data_b = 8'h00; miso_mode_b = 2'd0;
      step();
      step();
      check("reset_a_ctl", {sclk_a, mosi_a, ss_n_a, done_a, busy_a}, 5'b00100);
      check("reset_a_rx_drop", {rx_a, drop_a}, 16'h0000);
      check("reset_b_ctl", {sclk_b, mosi_b, ss_n_b, done_b, busy_b}, 5'b10100);
      check("reset_b_rx_drop", {rx_b, drop_b}, 16'h0000);
      reset_a = 1'b0;
      reset_b = 1'b0;
      step();

      // Table-driven single transfers.
      for (int i = 0; i < 8; i++) begin
         div = vecs[i].inst ? 3 : 1;
         xfer(vecs[i].inst, vecs[i].data, vecs[i].mode, bits, nbits, ss_low, done_c, done_n,
              lead1, lead2, busy_end);
         check($sformatf("v%0d_mosi_bits", i), bits, vecs[i].data);
         check($sformatf("v%0d_nlead", i), nbits, 8);
         check($sformatf("v%0d_ss_low", i), ss_low, 18*div);
         check($sformatf("v%0d_done_at", i), done_c, 18*div);
         check($sformatf("v%0d_done_width", i), done_n, 1);
         check($sformatf("v%0d_lead1", i), lead1, div);
         check($sformatf("v%0d_lead2", i), lead2, 3*div);
         check($sformatf("v%0d_rx", i), vecs[i].inst ? rx_b : rx_a, vecs[i].exp_rx);
         check($sformatf("v%0d_busy_end", i), busy_end, 1'b0);
      end
      check("table_drop_a", drop_a, 8'd0);
      check("table_drop_b", drop_b, 8'd0);

      // START toggling every cycle from reset, DATA incrementing.
      miso_mode_a = 2'd0;
      reset_a = 1'b1; start_a = 1'b0;
      step();
      step();
      for (int i = 0; i <= 22; i++) begin
         reset_a = 1'b0;
         start_a = (i % 2 == 0);
         data_a  = 8'h10 + 8'(i);
         step();
         if (i == 0)  check("t3_no_edge_after_reset", busy_a, 1'b0);
         if (i == 2)  check("t3_first_accept", {busy_a, ss_n_a}, 2'b10);
         if (i == 20) check("t3_done", done_a, 1'b1);
         if (i == 20) check("t3_rx1", rx_a, 8'h12);
         if (i == 21) check("t3_drop9", drop_a, 8'd9);
         if (i == 21) check("t3_idle_gap", {busy_a, ss_n_a}, 2'b01);
         if (i == 22) check("t3_second_accept", busy_a, 1'b1);
      end
      start_a = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (done_a) got = 1'b1;
      end
      check("t3_done2_seen", got, 1'b1);
      check("t3_rx2", rx_a, 8'h26);
      check("t3_drop_final", drop_a, 8'd9);

      // Reset at the 5th SCLK rising edge with START held high.
      data_a = 8'hC3; start_a = 1'b1; rising = 0; done_seen = 1'b0;
      prev = sclk_a;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!prev && sclk_a) rising++;
         prev = sclk_a;
         done_seen |= done_a;
      end
      check("t4_rising_count", rising, 5);
      check("t4_sclk_high", sclk_a, 1'b1);
      reset_a = 1'b1;
      step();
      check("t4_after_reset_ctl", {ss_n_a, sclk_a, busy_a}, 3'b100);
      check("t4_after_reset_drop", drop_a, 8'd0);
      done_seen |= done_a;
      reset_a = 1'b0;
      busy_seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step();
         done_seen |= done_a;
         busy_seen |= busy_a;
      end
      check("t4_no_done", done_seen, 1'b0);
      check("t4_start_held_no_edge", busy_seen, 1'b0);
      start_a = 1'b0;
      step();

      // Saturation of the drop counter.
      for (int i = 0; i < 800; i++) begin
         start_a = (i % 2 == 0);
         step();
      end
      check("t5_drop_sat", drop_a, 8'hFF);
      for (int i = 0; i < 200; i++) begin
         start_a = (i % 2 == 0);
         step();
      end
      check("t5_drop_stays", drop_a, 8'hFF);
      start_a = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         step();
         if (!busy_a) got = 1'b1;
      end
      check("t5_idle_after", got, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
